// File: rtl/cnn_sequencer.sv
// Frame-level controller for the CNN datapath: loads a USB pixel frame into the
// image buffer, runs conv/pool/fc(/bp) engines, then argmaxes the FC logits.
module cnn_sequencer #(
    parameter int IMAGE_PIXELS = 784,
    parameter int NUM_CLASSES  = 10,
    parameter int LOGIT_W      = 16,
    parameter int ADDR_W       = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                usb_data_in,
    input  logic                      usb_data_valid,
    output logic                      usb_data_accept,
    input  logic                      mode_train,
    output logic                      buf_wr_en,
    output logic [ADDR_W-1:0]         buf_wr_addr,
    output logic [7:0]                buf_wr_data,
    output logic                      conv_start,
    output logic                      pool_start,
    output logic                      fc_start,
    output logic                      bp_start,
    input  logic                      conv_done,
    input  logic                      pool_done,
    input  logic                      fc_done,
    input  logic                      bp_done,
    output logic [3:0]                logit_rd_addr,
    input  logic signed [LOGIT_W-1:0] logit_rd_data,
    output logic [7:0]                label_out,
    output logic [7:0]                usb_data_out,
    output logic                      usb_data_ready,
    input  logic                      usb_data_ack,
    output logic                      busy,
    output logic                      err_label
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_LABEL  = 4'd2;
    localparam logic [3:0] S_CONV   = 4'd3;
    localparam logic [3:0] S_POOL   = 4'd4;
    localparam logic [3:0] S_FC     = 4'd5;
    localparam logic [3:0] S_ARGMAX = 4'd6;
    localparam logic [3:0] S_BP     = 4'd7;
    localparam logic [3:0] S_OUTPUT = 4'd8;

    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMAGE_PIXELS - 1);
    localparam logic [7:0]        MAX_LABEL = 8'(NUM_CLASSES - 1);
    localparam logic [3:0]        LAST_ADDR = 4'(NUM_CLASSES - 1);
    localparam logic [3:0]        LAST_STEP = 4'(NUM_CLASSES);

    logic [3:0]                state_q, state_d;
    logic [ADDR_W-1:0]         pix_cnt;
    logic                      train_q;
    logic                      bp_ok;
    logic [3:0]                step;
    logic [3:0]                best_idx;
    logic [3:0]                best_idx_nx;
    logic signed [LOGIT_W-1:0] best_val;
    logic                      xfer;
    logic                      load_xfer;
    logic                      enter;
    logic                      best_upd;

    assign xfer      = usb_data_valid && usb_data_accept;
    assign load_xfer = xfer && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign enter     = (state_d != state_q);

    // Logit for index step-1 arrives while step is on the bus; the first one seeds best.
    assign best_upd    = (state_q == S_ARGMAX) && (step != 4'd0) &&
                         ((step == 4'd1) || (logit_rd_data > best_val));
    assign best_idx_nx = best_upd ? (step - 4'd1) : best_idx;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (xfer) state_d = S_LOAD;
            S_LOAD:   if (xfer && (pix_cnt == LAST_PIX)) state_d = train_q ? S_LABEL : S_CONV;
            S_LABEL:  if (xfer) state_d = S_CONV;
            S_CONV:   if (!conv_start && conv_done) state_d = S_POOL;
            S_POOL:   if (!pool_start && pool_done) state_d = S_FC;
            S_FC:     if (!fc_start && fc_done) state_d = S_ARGMAX;
            S_ARGMAX: if (step == LAST_STEP) state_d = (train_q && bp_ok) ? S_BP : S_OUTPUT;
            S_BP:     if (!bp_start && bp_done) state_d = S_OUTPUT;
            S_OUTPUT: if (usb_data_ack && usb_data_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pix_cnt         <= '0;
            train_q         <= 1'b0;
            bp_ok           <= 1'b0;
            step            <= '0;
            best_idx        <= '0;
            best_val        <= '0;
            usb_data_accept <= 1'b0;
            busy            <= 1'b0;
            buf_wr_en       <= 1'b0;
            buf_wr_addr     <= '0;
            buf_wr_data     <= '0;
            conv_start      <= 1'b0;
            pool_start      <= 1'b0;
            fc_start        <= 1'b0;
            bp_start        <= 1'b0;
            logit_rd_addr   <= '0;
            label_out       <= '0;
            usb_data_out    <= '0;
            usb_data_ready  <= 1'b0;
            err_label       <= 1'b0;
        end else begin
            state_q         <= state_d;
            usb_data_accept <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_LABEL);
            busy            <= (state_d != S_IDLE);
            conv_start      <= enter && (state_d == S_CONV);
            pool_start      <= enter && (state_d == S_POOL);
            fc_start        <= enter && (state_d == S_FC);
            bp_start        <= enter && (state_d == S_BP);
            err_label       <= 1'b0;
            buf_wr_en       <= load_xfer;
            if (load_xfer) begin
                buf_wr_addr <= (state_q == S_IDLE) ? '0 : pix_cnt;
                buf_wr_data <= usb_data_in;
            end
            if (best_upd) begin
                best_idx <= best_idx_nx;
                best_val <= logit_rd_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        train_q <= mode_train;
                        pix_cnt <= ADDR_W'(1);
                    end
                end
                S_LOAD: begin
                    if (xfer) pix_cnt <= pix_cnt + 1'b1;
                end
                S_LABEL: begin
                    if (xfer) begin
                        label_out <= usb_data_in;
                        if (usb_data_in > MAX_LABEL) begin
                            err_label <= 1'b1;
                            bp_ok     <= 1'b0;
                        end else begin
                            bp_ok     <= 1'b1;
                        end
                    end
                end
                S_ARGMAX: begin
                    step <= step + 4'd1;
                    if (logit_rd_addr != LAST_ADDR) logit_rd_addr <= logit_rd_addr + 4'd1;
                end
                S_OUTPUT: begin
                    if (usb_data_ack && usb_data_ready) usb_data_ready <= 1'b0;
                end
                default: ;
            endcase

            if (enter && (state_d == S_ARGMAX)) begin
                step          <= '0;
                logit_rd_addr <= '0;
            end
            // From ARGMAX the final comparison lands on this same edge, hence best_idx_nx.
            if (enter && (state_d == S_OUTPUT)) begin
                usb_data_out   <= 8'(best_idx_nx);
                usb_data_ready <= 1'b1;
            end
            if (enter && (state_d == S_IDLE)) pix_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cnn_sequencer.sv
// Self-checking bench for cnn_sequencer: random frames against a frame-level
// reference (expected buffer contents, engine order, argmax, label handling).
module tb_cnn_sequencer;

    localparam int IMAGE_PIXELS = 784;
    localparam int NUM_CLASSES  = 10;
    localparam int LOGIT_W      = 16;
    localparam int ADDR_W       = 10;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [7:0]                usb_data_in = 8'd0;
    logic                      usb_data_valid = 1'b0;
    logic                      usb_data_accept;
    logic                      mode_train = 1'b0;
    logic                      buf_wr_en;
    logic [ADDR_W-1:0]         buf_wr_addr;
    logic [7:0]                buf_wr_data;
    logic                      conv_start, pool_start, fc_start, bp_start;
    logic                      conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0, bp_done = 1'b0;
    logic [3:0]                logit_rd_addr;
    logic signed [LOGIT_W-1:0] logit_rd_data = '0;
    logic [7:0]                label_out;
    logic [7:0]                usb_data_out;
    logic                      usb_data_ready;
    logic                      usb_data_ack = 1'b0;
    logic                      busy;
    logic                      err_label;

    int checks = 0;
    int errors = 0;

    cnn_sequencer #(
        .IMAGE_PIXELS(IMAGE_PIXELS), .NUM_CLASSES(NUM_CLASSES),
        .LOGIT_W(LOGIT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .usb_data_in(usb_data_in), .usb_data_valid(usb_data_valid),
        .usb_data_accept(usb_data_accept), .mode_train(mode_train),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .conv_start(conv_start), .pool_start(pool_start), .fc_start(fc_start), .bp_start(bp_start),
        .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done), .bp_done(bp_done),
        .logit_rd_addr(logit_rd_addr), .logit_rd_data(logit_rd_data),
        .label_out(label_out), .usb_data_out(usb_data_out),
        .usb_data_ready(usb_data_ready), .usb_data_ack(usb_data_ack),
        .busy(busy), .err_label(err_label)
    );

    always #5 clk = ~clk;

    logic signed [LOGIT_W-1:0] logits [NUM_CLASSES];

    // FC logit memory: one-cycle read latency
    initial forever begin
        @(posedge clk);
        logit_rd_data <= (int'(logit_rd_addr) < NUM_CLASSES) ? logits[logit_rd_addr] : '0;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor and engine responders, all sampled/driven on the falling edge.
    int                cyc = 0;
    int                frame_id = 0;
    int                mon_frame = 0;
    logic [ADDR_W+7:0] got_wr [$];
    longint            seq = 0;
    int                err_cnt = 0, fc_cyc = -1000, exit_cyc = -1, sweep_err = 0, stray_at = -1;
    int                eng_cnt [4];
    logic [3:0]        starts, dones;
    bit                glitch_en = 1'b0;

    initial begin
        for (int e = 0; e < 4; e++) eng_cnt[e] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_id != mon_frame) begin
                mon_frame = frame_id;
                got_wr.delete();
                seq = 0; err_cnt = 0; fc_cyc = -1000; exit_cyc = -1; sweep_err = 0; stray_at = -1;
            end
            if (buf_wr_en) got_wr.push_back({buf_wr_addr, buf_wr_data});
            if (err_label) err_cnt++;
            if (conv_start) seq = (seq << 4) | 1;
            if (pool_start) seq = (seq << 4) | 3;
            if (fc_start)   seq = (seq << 4) | 5;
            if (bp_start)   seq = (seq << 4) | 7;
            if (cyc > fc_cyc && cyc <= fc_cyc + NUM_CLASSES && logit_rd_addr != 4'(cyc - fc_cyc - 1))
                sweep_err++;
            if (exit_cyc < 0 && fc_cyc >= 0 && (usb_data_ready || bp_start)) exit_cyc = cyc;
            starts = {bp_start, fc_start, pool_start, conv_start};
            dones  = '0;
            if (rst) begin
                for (int e = 0; e < 4; e++) eng_cnt[e] = 0;
            end else begin
                for (int e = 0; e < 4; e++) begin
                    if (eng_cnt[e] > 0) begin
                        eng_cnt[e]--;
                        if (eng_cnt[e] == 0) begin
                            dones[e] = 1'b1;
                            seq = (seq << 4) | longint'(2 * e + 2);
                            if (e == 2) fc_cyc = cyc;
                        end
                    end
                end
                if (glitch_en && conv_start) dones[0] = 1'b1;
                if (glitch_en && stray_at == cyc) dones[1] = 1'b1;
                for (int e = 0; e < 4; e++)
                    if (starts[e])
                        eng_cnt[e] = (glitch_en && e == 0) ? int'($urandom_range(3, 6))
                                                           : int'($urandom_range(1, 5));
                if (glitch_en && conv_start) stray_at = cyc + 1;
            end
            {bp_done, fc_done, pool_done, conv_done} = dones;
        end
    end

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < NUM_CLASSES; i++)
            if (logits[i] > logits[best]) best = i;
        return best;
    endfunction

    task automatic random_logits();
        for (int i = 0; i < NUM_CLASSES; i++) logits[i] = LOGIT_W'($urandom);
        logits[$urandom_range(0, NUM_CLASSES - 1)] = 16'sh7fff;
        logits[$urandom_range(5, 9)] = logits[$urandom_range(0, 4)];
    endtask

    // Caller is positioned at a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        usb_data_in    = b;
        usb_data_valid = 1'b1;
        while (!usb_data_accept && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("accept_timeout", longint'(t), 0);
        @(negedge clk);
        if (gap) begin
            usb_data_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input bit train, input logic [7:0] label, input bit glitch,
                             input bit gap, input bit ramp, input int ack_wait);
        logic [7:0] px [IMAGE_PIXELS];
        int         exp_cls, t, bad, unstable;
        logic [7:0] first_out;
        bit         bp_exp;
        exp_cls   = ref_argmax();
        bp_exp    = train && (int'(label) < NUM_CLASSES);
        glitch_en = glitch;
        frame_id++;
        @(negedge clk);
        for (int n = 0; n < IMAGE_PIXELS; n++) begin
            px[n]      = ramp ? 8'(n) : 8'($urandom);
            mode_train = (n == 0) ? train : 1'($urandom);
            if (glitch) usb_data_ack = (n == 10);
            send_byte(px[n], gap);
        end
        usb_data_ack = 1'b0;
        if (train) send_byte(label, gap);
        usb_data_valid = 1'b0;
        mode_train     = 1'b0;
        t = 0;
        while (!usb_data_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("ready_seen", longint'(t < 5000), 1);
        check("class", longint'(usb_data_out), longint'(exp_cls));
        first_out = usb_data_out;
        unstable  = 0;
        for (int i = 0; i < ack_wait; i++) begin
            @(negedge clk);
            if (!usb_data_ready || usb_data_out != first_out) unstable++;
        end
        check("hold_until_ack", longint'(unstable), 0);
        usb_data_ack = 1'b1;
        @(negedge clk);
        usb_data_ack = 1'b0;
        check("ready_drop", longint'(usb_data_ready), 0);
        check("busy_idle", longint'(busy), 0);
        check("engine_seq", seq, bp_exp ? 64'h12345678 : 64'h123456);
        check("argmax_len", longint'(exit_cyc - fc_cyc), longint'(NUM_CLASSES + 2));
        check("rd_sweep", longint'(sweep_err), 0);
        check("err_label", longint'(err_cnt), (train && int'(label) >= NUM_CLASSES) ? 1 : 0);
        if (train) check("label_out", longint'(label_out), longint'(label));
        check("wr_count", longint'(got_wr.size()), longint'(IMAGE_PIXELS));
        bad = 0;
        for (int n = 0; n < IMAGE_PIXELS && n < got_wr.size(); n++)
            if (got_wr[n] != {ADDR_W'(n), px[n]}) bad++;
        check("wr_content", longint'(bad), 0);
        glitch_en = 1'b0;
    endtask

    initial begin
        int tmp;
        repeat (3) @(negedge clk);
        check("reset_outputs", longint'({usb_data_accept, buf_wr_en, buf_wr_addr, buf_wr_data,
              conv_start, pool_start, fc_start, bp_start, logit_rd_addr, label_out,
              usb_data_out, usb_data_ready, busy, err_label}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        logits = '{16'sd5, -16'sd3, 16'sd40, 16'sd40, 16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        run_frame(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 3);

        random_logits();
        run_frame(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 2);

        random_logits();
        run_frame(1'b1, 8'd12, 1'b0, 1'b0, 1'b0, 2);

        for (int i = 0; i < NUM_CLASSES; i++) begin
            tmp = int'($urandom_range(3, 32768));
            logits[i] = LOGIT_W'(-tmp);
        end
        logits[0] = -16'sd100; logits[1] = -16'sd2; logits[2] = -16'sd50;
        run_frame(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1);

        random_logits();
        run_frame(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 20);

        // Abort mid-frame with an asynchronous reset
        frame_id++;
        @(negedge clk);
        for (int n = 0; n <= 300; n++) send_byte(8'(n), 1'b0);
        usb_data_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midframe_reset_outputs", longint'({usb_data_accept, buf_wr_en, buf_wr_addr, buf_wr_data,
              conv_start, pool_start, fc_start, bp_start, logit_rd_addr, label_out,
              usb_data_out, usb_data_ready, busy, err_label}), 0);
        frame_id++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_writes", longint'(got_wr.size()), 0);
        check("abort_no_starts", seq, 0);
        check("abort_idle", longint'(busy), 0);

        random_logits();
        run_frame(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 2);

        for (int f = 0; f < 2; f++) begin
            random_logits();
            run_frame(1'($urandom), 8'($urandom_range(0, 15)), 1'b0, 1'($urandom), 1'b0,
                      int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_sequencer.md
Name: cnn_sequencer

Overview:
Frame-level controller for the CNN inference/training datapath. Accepts a USB byte stream (784 pixels, plus a label byte in training mode) and writes it into the image buffer. Sequences the conv, pool, fully-connected and backprop engines with start/done handshakes, then runs an argmax over the FC logits. Returns the predicted class over the USB output handshake.

Parameters:
IMAGE_PIXELS, 784, pixel bytes per frame
NUM_CLASSES, 10, number of FC logits
LOGIT_W, 16, logit width, signed two's complement
ADDR_W, 10, image buffer address width (must satisfy 2^ADDR_W >= IMAGE_PIXELS)

Ports:
clk  in  1  clock
rst  in  1  reset
usb_data_in  in  8  pixel or label byte
usb_data_valid  in  1  byte valid
usb_data_accept  out  1  sequencer can take a byte this cycle
mode_train  in  1  1 = training frame, 0 = inference; sampled on first pixel
buf_wr_en  out  1  image buffer write strobe
buf_wr_addr  out  ADDR_W  image buffer write address
buf_wr_data  out  8  image buffer write data
conv_start, pool_start, fc_start, bp_start  out  1 each  single-cycle start pulses
conv_done, pool_done, fc_done, bp_done  in  1 each  engine completion
logit_rd_addr  out  4  FC logit read index
logit_rd_data  in  LOGIT_W  logit at logit_rd_addr, valid one cycle after the address
label_out  out  8  latched label for backprop
usb_data_out  out  8  predicted class
usb_data_ready  out  1  result valid
usb_data_ack  in  1  host consumed result
busy  out  1  high in every state except IDLE
err_label  out  1  one-cycle pulse when the label is > NUM_CLASSES-1

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0; state = IDLE; pixel counter = 0. Asserting reset mid-frame aborts the frame with no further buffer writes or starts.
- A byte is transferred when usb_data_valid && usb_data_accept. usb_data_accept = 1 only in IDLE, LOAD and LABEL.
- IDLE: on the first transfer, latch mode_train into train_q, write the byte at address 0, set the counter to 1, and go to LOAD.
- LOAD: each transfer writes at the counter value, then the counter increments. Once pixel IMAGE_PIXELS-1 is written, go to LABEL if train_q, else CONV.
- Buffer write timing: buf_wr_en/addr/data are registered and asserted the cycle after the transfer. Gaps in valid are allowed.
- LABEL: the next transfer latches label_out. If the label exceeds NUM_CLASSES-1, pulse err_label and clear bp_ok; otherwise set bp_ok. Go to CONV.
- Engine states CONV, POOL, FC, BP:
  - On entry, pulse the matching *_start for exactly one cycle.
  - Wait for the matching *_done, sampled only from the cycle after the start pulse onward. A done in the start cycle is ignored.
  - Unrelated done inputs are ignored.
  - Transitions: CONV→POOL→FC→ARGMAX.
- ARGMAX:
  - Drive logit_rd_addr = 0..NUM_CLASSES-1 on consecutive cycles; data returns one cycle later.
  - Compare signed; update best only on strictly greater, so ties keep the lowest index.
  - Occupancy is exactly NUM_CLASSES+1 cycles.
  - Exit to BP if train_q && bp_ok, else OUTPUT.
- BP: same handshake as the other engine states; exit to OUTPUT.
- OUTPUT:
  - Assert usb_data_out = best index (zero-extended) and usb_data_ready = 1. Both hold stable until usb_data_ack.
  - On the ack cycle, drop usb_data_ready and go to IDLE.
  - An ack while usb_data_ready = 0 is ignored.
- Counter width is ADDR_W. The counter clears on entering IDLE and never wraps within a frame.
- Bytes presented while usb_data_accept = 0 are not consumed. The source must hold them.

Test Plan:
- Inference frame: 784 bytes, pixel n = n mod 256, mode_train = 0; FC logits {5,-3,40,40,7,...,0} → buf writes addr 0..783 with matching data; start pulses conv, pool, fc in order, no bp_start; usb_data_out = 2 (tie keeps lowest index); usb_data_ready held until ack, then busy = 0.
- Training frame: 784 pixels plus label byte 7 → label_out = 7; bp_start pulses exactly once after ARGMAX; result is output after bp_done.
- Bad label: training frame with label 12 → err_label pulses once, no bp_start, result still output.
- All-negative logits {-100,-2,-50,...} → usb_data_out = 1. ARGMAX lasts 11 cycles; logit_rd_addr sweeps 0..9.
- Handshake robustness: valid toggled every other cycle while loading; conv_done held high during the conv_start cycle; pool_done pulsed during CONV; ack withheld 20 cycles → pixels stored contiguously; early conv_done ignored and real done honoured; stray pool_done ignored; output stable until ack.
- Reset after pixel 300 → all outputs 0 and state IDLE. A new full frame then completes normally, starting again at addr 0.
